// File: rtl/spi_param_loader.sv
// spi_param_loader
//   Accepts 32-bit command words from an SPI byte assembler and maintains a
//   bank of sixteen 16-bit parameter registers for a neuron core.
//   Commands: NOP, WRITE, READ (4-byte response), START, STOP, CLEAR.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   word_valid     one-cycle strobe, word_in carries a complete command word
//   word_in[31:0]  [31:28] opcode, [27] parity/reserved, [23:20] addr, [15:0] data
//   word_ready     high only while idle; word taken when word_valid & word_ready
//   tx_byte[7:0]   response byte toward the SPI transmit path
//   tx_valid       tx_byte is valid; held until tx_ack
//   tx_ack         transmit path has taken tx_byte
//   rd_addr[3:0]   core read address
//   rd_data[15:0]  combinational read of param[rd_addr]
//   run_enable     core run flag
//   cmd_err        one-cycle error pulse
//   err_count[7:0] saturating error counter
//
// Build option
//   SPI_PARAM_PARITY_EN : when defined, the XOR of all 32 bits of an accepted
//   word must be 0, otherwise the command is rejected as an error.

module spi_param_loader (
   input  logic        clk,
   input  logic        rst,
   input  logic        word_valid,
   input  logic [31:0] word_in,
   output logic        word_ready,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ack,
   input  logic [3:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic        run_enable,
   output logic        cmd_err,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_CLEAR,
      S_RESP
   } state_e;

   state_e      state_q;
   logic [3:0]  op_q;
   logic [3:0]  addr_q;
   logic [15:0] data_q;
   logic [15:0] param_q [16];
   logic [15:0] snap_q;
   logic [3:0]  clr_q;
   logic [1:0]  byte_idx_q;
   logic [7:0]  tx_byte_q;
   logic        tx_valid_q;
   logic        run_q;
   logic        cmd_err_q;
   logic [7:0]  err_cnt_q;
   logic [7:0]  err_cnt_d;

   logic        overrun;
   logic        par_err;
   logic        exec_err;
   logic [8:0]  err_sum;
   logic [7:0]  resp_b0;

`ifdef SPI_PARAM_PARITY_EN
   logic        par_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= 1'b0;
      end else if (word_valid && state_q == S_IDLE) begin
         par_q <= ^word_in;
      end
   end

   assign par_err = par_q;
`else
   logic        unused_rsvd;

   assign unused_rsvd = ^{word_in[27:24], word_in[19:16]};
   assign par_err     = 1'b0;
`endif

   assign overrun  = word_valid && (state_q != S_IDLE);
   assign exec_err = (state_q == S_EXEC) && (par_err || (op_q > 4'h5));
   assign resp_b0  = {4'h2, addr_q};

   // Overrun and decode error in the same cycle both count; clamp at 255.
   always_comb begin
      err_sum   = {1'b0, err_cnt_q} + {8'd0, overrun} + {8'd0, exec_err};
      err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         param_q    <= '{default: '0};
         snap_q     <= '0;
         clr_q      <= '0;
         byte_idx_q <= '0;
         tx_byte_q  <= '0;
         tx_valid_q <= 1'b0;
         run_q      <= 1'b0;
         cmd_err_q  <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         cmd_err_q <= overrun || exec_err;
         err_cnt_q <= err_cnt_d;

         case (state_q)
            S_IDLE: begin
               if (word_valid) begin
                  op_q    <= word_in[31:28];
                  addr_q  <= word_in[23:20];
                  data_q  <= word_in[15:0];
                  state_q <= S_EXEC;
               end
            end

            S_EXEC: begin
               state_q <= S_IDLE;
               if (!exec_err) begin
                  case (op_q)
                     4'h1: param_q[addr_q] <= data_q;
                     4'h2: begin
                        snap_q     <= param_q[addr_q];
                        tx_byte_q  <= resp_b0;
                        tx_valid_q <= 1'b1;
                        byte_idx_q <= '0;
                        state_q    <= S_RESP;
                     end
                     4'h3: run_q <= 1'b1;
                     4'h4: run_q <= 1'b0;
                     4'h5: begin
                        clr_q   <= '0;
                        state_q <= S_CLEAR;
                     end
                     default: ;
                  endcase
               end
            end

            S_CLEAR: begin
               param_q[clr_q] <= '0;
               clr_q          <= clr_q + 4'd1;
               if (clr_q == 4'hF) begin
                  state_q <= S_IDLE;
               end
            end

            S_RESP: begin
               // Next byte is loaded on the ack edge so it shows one cycle later.
               if (tx_ack && tx_valid_q) begin
                  byte_idx_q <= byte_idx_q + 2'd1;
                  case (byte_idx_q)
                     2'd0: tx_byte_q <= snap_q[15:8];
                     2'd1: tx_byte_q <= snap_q[7:0];
                     2'd2: tx_byte_q <= resp_b0 ^ snap_q[15:8] ^ snap_q[7:0];
                     default: begin
                        tx_byte_q  <= '0;
                        tx_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                     end
                  endcase
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign word_ready = (state_q == S_IDLE);
   assign tx_byte    = tx_byte_q;
   assign tx_valid   = tx_valid_q;
   assign rd_data    = param_q[rd_addr];
   assign run_enable = run_q;
   assign cmd_err    = cmd_err_q;
   assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_spi_param_loader.sv
module tb_spi_param_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        word_valid = 1'b0;
   logic [31:0] word_in = '0;
   logic        word_ready;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ack = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic [15:0] rd_data;
   logic        run_enable;
   logic        cmd_err;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] pm [16];
   int          err_m;
   logic        run_m;

   spi_param_loader dut (
      .clk        (clk),
      .rst        (rst),
      .word_valid (word_valid),
      .word_in    (word_in),
      .word_ready (word_ready),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_ack     (tx_ack),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .run_enable (run_enable),
      .cmd_err    (cmd_err),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Word with random reserved bits and bit 27 chosen for even overall parity.
   function automatic logic [31:0] mkword(input logic [3:0] op, input logic [3:0] a,
                                          input logic [15:0] d);
      logic [31:0] w;
      w = {op, 1'b0, 3'($urandom), a, 4'($urandom), d};
      w[27] = ^w;
      return w;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      word_valid = 1'b0;
      tx_ack = 1'b0;
      tick();
      tick();
      pm = '{default: 16'h0};
      err_m = 0;
      run_m = 1'b0;
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_byte", tx_byte, 8'h00);
      check("rst_run", run_enable, 1'b0);
      check("rst_err_count", err_count, 8'h00);
      check("rst_cmd_err", cmd_err, 1'b0);
      rd_addr = 4'($urandom);
      #1;
      check("rst_param", rd_data, 16'h0000);
      rst = 1'b0;
      check("ready_after_rst", word_ready, 1'b1);
   endtask

   task automatic issue(input logic [31:0] w);
      check("ready_before_word", word_ready, 1'b1);
      word_in = w;
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      check("ready_low_in_exec", word_ready, 1'b0);
      tick();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!word_ready && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run_cmd(input logic [31:0] w, input int ack_dly);
      logic [3:0]  op;
      logic [3:0]  a;
      logic [15:0] d;
      logic        bad;
      logic [7:0]  exp_b [4];
      int          n;
      op = w[31:28];
      a = w[23:20];
      d = w[15:0];
      bad = (op > 4'h5);
`ifdef SPI_PARAM_PARITY_EN
      if (^w) bad = 1'b1;
`endif
      rd_addr = a;
      exp_b[0] = {4'h2, a};
      exp_b[1] = pm[a][15:8];
      exp_b[2] = pm[a][7:0];
      exp_b[3] = exp_b[0] ^ exp_b[1] ^ exp_b[2];
      issue(w);
      if (bad) err_m = (err_m >= 255) ? 255 : err_m + 1;
      check("cmd_err_after_exec", cmd_err, bad);
      if (!bad) begin
         case (op)
            4'h1: pm[a] = d;
            4'h3: run_m = 1'b1;
            4'h4: run_m = 1'b0;
            4'h5: pm = '{default: 16'h0};
            default: ;
         endcase
      end
      if (!bad && op == 4'h2) begin
         for (int k = 0; k < 4; k++) begin
            check("resp_valid", tx_valid, 1'b1);
            check("resp_byte", tx_byte, exp_b[k]);
            for (int j = 0; j < ack_dly; j++) begin
               tick();
               check("resp_hold_valid", tx_valid, 1'b1);
               check("resp_hold_byte", tx_byte, exp_b[k]);
            end
            tx_ack = 1'b1;
            tick();
            tx_ack = 1'b0;
         end
         check("resp_done_valid", tx_valid, 1'b0);
         check("resp_done_ready", word_ready, 1'b1);
      end else if (!bad && op == 4'h5) begin
         wait_ready(n);
         check("clear_cycles", n, 16);
      end else begin
         check("ready_after_exec", word_ready, 1'b1);
      end
      tick();
      check("rd_data", rd_data, pm[a]);
      check("run_enable", run_enable, run_m);
      check("err_count", err_count, err_m[7:0]);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] wbad;
      int          r;
      int          n;
      logic [3:0]  op;

      do_reset();

      // Directed write then read-back response with a 2-cycle ack delay.
      run_cmd(32'h1030_BEEF, 0);
      run_cmd(mkword(4'h2, 4'h3, 16'h0000), 2);

      // Stray ack while nothing is offered.
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      check("stray_ack_valid", tx_valid, 1'b0);
      check("stray_ack_byte", tx_byte, 8'h00);
      check("stray_ack_ready", word_ready, 1'b1);

      // Randomized command mix.
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 19);
         if (r < 6)       op = 4'h1;
         else if (r < 9)  op = 4'h2;
         else if (r < 11) op = 4'h0;
         else if (r < 13) op = 4'h3;
         else if (r < 15) op = 4'h4;
         else if (r == 15) op = 4'h5;
         else             op = 4'($urandom_range(6, 15));
         run_cmd(mkword(op, 4'($urandom), 16'($urandom)), $urandom_range(0, 3));
      end

      // Bit 27 handling: rejected under parity, ignored otherwise.
      do_reset();
      w = mkword(4'h1, 4'h5, 16'hA5A5);
      wbad = w ^ 32'h0800_0000;
      run_cmd(wbad, 0);
`ifdef SPI_PARAM_PARITY_EN
      check("parity_err_count", err_count, 8'd1);
      run_cmd(w, 0);
      check("parity_good_write", rd_data, 16'hA5A5);
`else
      check("nopar_write", rd_data, 16'hA5A5);
`endif

      // Overrun during EXEC of an illegal word: two errors, one pulse.
      do_reset();
      word_in = mkword(4'h9, 4'h1, 16'h1111);
      word_valid = 1'b1;
      tick();
      word_in = mkword(4'h9, 4'h2, 16'h2222);
      check("ovr_ready_low", word_ready, 1'b0);
      tick();
      word_valid = 1'b0;
      err_m = 2;
      check("ovr_cmd_err", cmd_err, 1'b1);
      check("ovr_err_count", err_count, 8'd2);
      tick();
      check("ovr_single_pulse", cmd_err, 1'b0);
      check("ovr_err_hold", err_count, 8'd2);
      for (int i = 0; i < 300; i++) begin
         run_cmd(mkword(4'($urandom_range(6, 15)), 4'($urandom), 16'($urandom)), 0);
      end
      check("err_saturated", err_count, 8'd255);

      // START, CLEAR, and a write dropped as an overrun mid-clear.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         run_cmd(mkword(4'h1, 4'(i), 16'($urandom_range(1, 65535))), 0);
      end
      run_cmd(mkword(4'h3, 4'h0, 16'h0000), 0);
      issue(mkword(4'h5, 4'h0, 16'h0000));
      pm = '{default: 16'h0};
      for (int i = 0; i < 4; i++) tick();
      word_in = mkword(4'h1, 4'h7, 16'h1234);
      word_valid = 1'b1;
      tick();
      word_valid = 1'b0;
      err_m = 1;
      check("clr_ovr_cmd_err", cmd_err, 1'b1);
      wait_ready(n);
      check("clr_cycles", n + 5, 16);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         tick();
         check("clr_param_zero", rd_data, 16'h0000);
      end
      check("clr_err_count", err_count, 8'd1);
      check("clr_run_kept", run_enable, 1'b1);

      // Reset in the middle of a response, colliding with word_valid and tx_ack.
      do_reset();
      run_cmd(32'h1030_BEEF, 0);
      rd_addr = 4'h3;
      issue(mkword(4'h2, 4'h3, 16'h0000));
      check("mid_b0", tx_byte, 8'h23);
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      check("mid_b1", tx_byte, 8'hBE);
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      check("mid_b2", tx_byte, 8'hEF);
      rst = 1'b1;
      tx_ack = 1'b1;
      word_in = mkword(4'h1, 4'h3, 16'h5555);
      word_valid = 1'b1;
      tick();
      check("abort_tx_valid", tx_valid, 1'b0);
      check("abort_tx_byte", tx_byte, 8'h00);
      check("abort_param3", rd_data, 16'h0000);
      check("abort_ready", word_ready, 1'b1);
      rst = 1'b0;
      tx_ack = 1'b0;
      word_valid = 1'b0;
      tick();
      check("after_abort_valid", tx_valid, 1'b0);
      check("after_abort_ready", word_ready, 1'b1);
      check("after_abort_param3", rd_data, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
